// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types and encodings for the multi-cycle control FSM
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_ADDR,
    S_MEM_RD,
    S_WB_M,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT,
    S_ERROR
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that own the shared memory port and therefore can stall
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_source;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_ctrl;
  logic [CNT_W-1:0] instr_count;
  logic             halted;
  logic             err;

  modport master (
    input  run, opcode, funct, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_source,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
           instr_count, halted, err
  );

  modport slave (
    output run, opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_source,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
           instr_count, halted, err
  );
endinterface

// File: rtl/multicycle_ctrl_alu_ctrl_dec.sv
// rtl/multicycle_ctrl_alu_ctrl_dec.sv - R-type funct to ALU operation decoder with legality flag
module alu_ctrl_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       legal_o
);

  // Map funct to ALU op; unknown functs fall back to ADD and are flagged illegal
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      FN_SLL:  alu_ctrl_o = ALU_SLL;
      default: legal_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS-subset control FSM with shared memory port
module multicycle_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);
  import ctrl_pkg::*;

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  // The WAIT_MAX-th consecutive stalled cycle is the last one tolerated
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire;
  logic [3:0]        fn_alu;
  logic              fn_legal;

  alu_ctrl_dec u_alu_ctrl_dec (
    .funct_i    (bus.funct),
    .alu_ctrl_o (fn_alu),
    .legal_o    (fn_legal)
  );

  // State, retired count and stall counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Next state, instruction retirement and memory stall timeout
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = fn_legal ? S_EXEC_R : S_ERROR;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default:      state_d = S_ERROR;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (bus.mem_ready) state_d = S_WB_M;
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = bus.run ? S_FETCH : S_IDLE;
        end
      end
      S_WB_R, S_WB_I, S_WB_M, S_BRANCH, S_JUMP: begin
        retire  = 1'b1;
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT:   state_d = S_HALT;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase

    if (is_mem_state(state_q) && !bus.mem_ready) begin
      if (wait_q == WAIT_LAST) state_d = S_ERROR;
      else                     wait_d  = wait_q + 1'b1;
    end

    cnt_d = (retire && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  // Moore strobes from the registered state; FETCH and BRANCH gate PC/IR loads
  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_source  = PCSRC_ALU;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_B;
    bus.alu_ctrl   = ALU_ADD;
    bus.halted     = 1'b0;
    bus.err        = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = SRCB_IMM_SH;
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = fn_alu;
      end
      S_WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_WB_I: bus.reg_write = 1'b1;
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_WB_M: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = ALU_SUB;
        bus.pc_source = PCSRC_ALUOUT;
        bus.pc_write  = bus.zero;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
      end
      S_HALT:  bus.halted = 1'b1;
      S_ERROR: bus.err    = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;
  localparam int WAIT_MAX = 8;

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_EXR, P_WBR, P_EXI, P_WBI, P_ADDR,
                P_MRD, P_WBM, P_MWR, P_BR, P_JMP, P_HALT, P_ERR} ph_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic       rdy;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
    ph_t        ph;
    int         cnt;
  } rec_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       halted;
    logic       err;
    logic [3:0] cnt;
  } out_t;

  logic clk;
  logic reset;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) dif ();

  multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  rec_t q[$];
  rec_t cur;
  bit   cur_valid = 0;

  int         m_cnt  = 0;
  bit         m_idle = 1;
  logic [5:0] g_op, g_fn;
  logic       g_z, g_run;

  function automatic int sat(int c);
    return (c < CNT_MAX) ? c + 1 : CNT_MAX;
  endfunction

  function automatic logic [3:0] fn_alu(logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      6'h00:   return 4'b1000;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic bit fn_ok(logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
  endfunction

  // Expected output vector for one cycle of a given phase
  function automatic out_t model_out(rec_t r);
    out_t o;
    o = '0;
    o.alu_ctrl = 4'b0010;
    o.cnt = r.cnt[3:0];
    case (r.ph)
      P_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = r.rdy; o.pc_write = r.rdy; end
      P_DECODE: o.alu_src_b = 2'b11;
      P_EXR:    begin o.alu_src_a = 1; o.alu_ctrl = fn_alu(r.fn); end
      P_WBR:    begin o.reg_write = 1; o.reg_dst = 1; end
      P_EXI, P_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_WBI:    o.reg_write = 1;
      P_MRD:    begin o.mem_read = 1; o.iord = 1; end
      P_WBM:    begin o.reg_write = 1; o.mem_to_reg = 1; end
      P_MWR:    begin o.mem_write = 1; o.iord = 1; end
      P_BR:     begin o.alu_src_a = 1; o.alu_ctrl = 4'b0110; o.pc_source = 2'b01; o.pc_write = r.z; end
      P_JMP:    begin o.pc_write = 1; o.pc_source = 2'b10; end
      P_HALT:   o.halted = 1;
      P_ERR:    o.err = 1;
      default:  ;
    endcase
    return o;
  endfunction

  task automatic push(ph_t ph, logic rdy);
    rec_t r;
    r.rst = 1'b1; r.run = g_run; r.rdy = rdy; r.z = g_z;
    r.op = g_op; r.fn = g_fn; r.ph = ph; r.cnt = m_cnt;
    q.push_back(r);
  endtask

  task automatic retire(ph_t ph, logic rdy);
    push(ph, rdy);
    m_cnt  = sat(m_cnt);
    m_idle = !g_run;
  endtask

  task automatic gen_dead(ph_t ph);
    for (int i = 0; i < 3; i++) push(ph, 1'b1);
  endtask

  task automatic gen_reset(int n);
    m_cnt = 0;
    m_idle = 1;
    for (int i = 0; i < n; i++) begin
      rec_t r;
      r.rst = 1'b0; r.run = 1'b1; r.rdy = 1'b1; r.z = 1'b0;
      r.op = 6'h00; r.fn = 6'h20; r.ph = P_IDLE; r.cnt = 0;
      q.push_back(r);
    end
  endtask

  task automatic gen_idle(int n, logic rv);
    g_run = rv;
    for (int i = 0; i < n; i++) push(P_IDLE, 1'b1);
  endtask

  task automatic mem_phase(ph_t ph, int stalls, output bit ok);
    for (int i = 0; i < stalls && i < WAIT_MAX; i++) push(ph, 1'b0);
    ok = (stalls < WAIT_MAX);
    if (!ok) gen_dead(P_ERR);
  endtask

  // Expand one instruction into its per-cycle expectations; n counts cycles from FETCH on
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rv,
                     input int fst, input int mst, output int n);
    bit ok;
    int base;
    g_op = op; g_fn = fn; g_z = z;
    if (m_idle) begin
      g_run = 1'b1;
      push(P_IDLE, 1'b0);
      m_idle = 0;
    end
    g_run = rv;
    base = q.size();
    mem_phase(P_FETCH, fst, ok);
    if (ok) begin
      push(P_FETCH, 1'b1);
      push(P_DECODE, 1'b0);
      case (op)
        6'h00: if (fn_ok(fn)) begin push(P_EXR, 1'b0); retire(P_WBR, 1'b0); end
               else gen_dead(P_ERR);
        6'h23: begin
          push(P_ADDR, 1'b0);
          mem_phase(P_MRD, mst, ok);
          if (ok) begin push(P_MRD, 1'b1); retire(P_WBM, 1'b0); end
        end
        6'h2B: begin
          push(P_ADDR, 1'b0);
          mem_phase(P_MWR, mst, ok);
          if (ok) retire(P_MWR, 1'b1);
        end
        6'h08: begin push(P_EXI, 1'b0); retire(P_WBI, 1'b0); end
        6'h04: retire(P_BR, 1'b0);
        6'h02: retire(P_JMP, 1'b0);
        6'h3F: begin m_cnt = sat(m_cnt); gen_dead(P_HALT); end
        default: gen_dead(P_ERR);
      endcase
    end
    n = q.size() - base;
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      @(negedge clk);
      cur = q.pop_front();
      reset         = cur.rst;
      dif.run       = cur.run;
      dif.mem_ready = cur.rdy;
      dif.zero      = cur.z;
      dif.opcode    = cur.op;
      dif.funct     = cur.fn;
      cur_valid     = 1;
    end
    #3;
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Compare every driven cycle against the model, away from the rising edge
  always begin
    @(negedge clk);
    #2;
    if (cur_valid) begin
      out_t e, a;
      e = model_out(cur);
      a = {dif.mem_read, dif.mem_write, dif.iord, dif.ir_write, dif.pc_write, dif.pc_source,
           dif.reg_write, dif.reg_dst, dif.mem_to_reg, dif.alu_src_a, dif.alu_src_b,
           dif.alu_ctrl, dif.halted, dif.err, dif.instr_count};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle t=%0t ph=%s op=%0h: got 0x%06h, expected 0x%06h",
                 $time, cur.ph.name(), cur.op, a, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    dif.run = 1'b1; dif.mem_ready = 1'b0; dif.zero = 1'b0;
    dif.opcode = 6'h00; dif.funct = 6'h20;
    g_op = 6'h00; g_fn = 6'h20; g_z = 1'b0; g_run = 1'b1;

    gen_reset(3); drain();
    lit("reset_state", {dif.mem_read, dif.alu_ctrl, dif.instr_count, dif.err, dif.halted},
        {1'b0, 4'b0010, 4'd0, 1'b0, 1'b0});

    gen(6'h00, 6'h20, 0, 1, 0, 0, n); lit("len_add", n, 4); drain();
    gen(6'h00, 6'h22, 0, 1, 0, 0, n); drain();
    gen(6'h00, 6'h24, 1, 1, 0, 0, n); drain();
    gen(6'h00, 6'h25, 0, 1, 0, 0, n); drain();
    gen(6'h00, 6'h2A, 0, 1, 0, 0, n); drain();
    gen(6'h00, 6'h00, 0, 1, 0, 0, n); drain();
    gen(6'h23, 6'h00, 0, 1, 0, 2, n); lit("len_lw_stall2", n, 7); drain();
    gen(6'h23, 6'h00, 0, 1, 1, 0, n); lit("len_lw_fstall1", n, 6); drain();
    gen(6'h2B, 6'h00, 0, 1, 0, 0, n); lit("len_sw", n, 4); drain();
    gen(6'h2B, 6'h00, 0, 1, 0, 3, n); lit("len_sw_stall3", n, 7); drain();
    gen(6'h04, 6'h00, 1, 1, 0, 0, n); lit("len_beq_taken", n, 3); drain();
    gen(6'h04, 6'h00, 0, 1, 0, 0, n); lit("len_beq_not", n, 3); drain();
    gen(6'h02, 6'h00, 0, 1, 0, 0, n); lit("len_j", n, 3); drain();
    gen(6'h08, 6'h00, 0, 1, 7, 0, n); lit("len_addi_fstall7", n, 11); drain();
    gen(6'h08, 6'h00, 0, 0, 0, 0, n); gen_idle(2, 1'b0); drain();
    lit("idle_after_run0", {dif.mem_read, dif.instr_count}, {1'b0, 4'd15});
    gen(6'h04, 6'h00, 1, 1, 0, 0, n); drain();
    gen(6'h3F, 6'h00, 0, 1, 0, 0, n); drain();
    lit("halt_saturated", {dif.halted, dif.instr_count}, {1'b1, 4'd15});

    gen_reset(2);
    gen(6'h00, 6'h20, 0, 1, 0, 0, n);
    gen(6'h3F, 6'h00, 0, 1, 0, 0, n); drain();
    lit("halt_count", {dif.halted, dif.err, dif.instr_count}, {1'b1, 1'b0, 4'd2});

    gen_reset(1);
    g_run = 1'b1; push(P_IDLE, 1'b0); push(P_FETCH, 1'b0);
    gen_reset(1); drain();
    lit("reset_drops_read", dif.mem_read, 1'b0);

    gen(6'h3E, 6'h00, 0, 1, 0, 0, n); drain();
    lit("illegal_op_err", {dif.err, dif.mem_read, dif.reg_write}, 3'b100);

    gen_reset(1);
    gen(6'h00, 6'h01, 0, 1, 0, 0, n); drain();
    lit("illegal_funct_err", {dif.err, dif.instr_count}, {1'b1, 4'd0});

    gen_reset(1);
    gen(6'h08, 6'h00, 0, 1, 8, 0, n); drain();
    lit("fetch_timeout_err", {dif.err, dif.mem_read}, 2'b10);

    gen_reset(1);
    gen(6'h23, 6'h00, 0, 1, 0, 8, n); drain();
    lit("memrd_timeout_err", {dif.err, dif.mem_read, dif.iord}, 3'b100);

    cur_valid = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the 32-bit MIPS-subset datapath (register file, ALU, shared instruction/data memory) one phase per clock.
- Replaces single-cycle combinational control so one memory port serves both fetch and load/store, with a ready handshake.
- Emits datapath select/enable strobes, a retired-instruction counter and error/halt status.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- WAIT_MAX, 8, max consecutive mem_ready-low cycles in a memory state before ERROR.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  start/continue execution; sampled in IDLE and at instruction completion.
- opcode  in  6  instruction register [31:26].
- funct  in  6  instruction register [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load instruction register.
- pc_write  out  1  PC load enable (already gated with zero in BRANCH).
- pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = memory data, 0 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = A register.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLL.
- instr_count  out  CNT_W  retired instructions, saturating.
- halted  out  1  HALT reached.
- err  out  1  illegal instruction or memory timeout; sticky.

Behaviour:
- Async reset (reset=0):
  - state = IDLE; instr_count = 0; wait counter = 0.
  - All outputs 0, except alu_ctrl = 0010.
- Moore outputs decoded from the registered state. Only exceptions:
  - pc_write in BRANCH = zero.
  - ir_write/pc_write in FETCH = mem_ready.
- States and transitions:
  - IDLE: run=1 -> FETCH.
  - FETCH: mem_read=1, iord=0, src_a=0, src_b=01, ADD, pc_source=00. mem_ready=1 -> DECODE.
  - DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut). Dispatch on opcode:
    - 0x00 -> EXEC_R if funct legal, else ERROR.
    - 0x23 or 0x2B -> ADDR.
    - 0x08 -> EXEC_I.
    - 0x04 -> BRANCH.
    - 0x02 -> JUMP.
    - 0x3F -> HALT.
    - anything else -> ERROR.
  - EXEC_R: src_a=1, src_b=00, alu_ctrl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL. -> WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0.
  - EXEC_I: src_a=1, src_b=10, ADD. -> WB_I.
  - WB_I: reg_write=1, reg_dst=0.
  - ADDR: src_a=1, src_b=10, ADD. Then 0x23 -> MEM_RD, 0x2B -> MEM_WR (opcode held stable by IR).
  - MEM_RD: mem_read=1, iord=1. mem_ready -> WB_M.
  - WB_M: reg_write=1, reg_dst=0, mem_to_reg=1.
  - MEM_WR: mem_write=1, iord=1. Completes on mem_ready.
  - BRANCH: src_a=1, src_b=00, SUB, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - HALT: halted=1. Terminal until reset.
  - ERROR: err=1, all strobes 0. Terminal until reset.
- Instruction completion:
  - Completion states: WB_R, WB_I, WB_M, MEM_WR with mem_ready, BRANCH, JUMP. HALT also counts once, on entry.
  - On completion: instr_count += 1, saturating at all-ones. Next state = FETCH if run=1, else IDLE.
  - run=0 mid-instruction has no effect until completion.
- Latency with mem_ready tied 1:
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
  - Each wait cycle adds 1.
- Memory timeout:
  - Wait counter increments while in FETCH/MEM_RD/MEM_WR with mem_ready=0; clears on mem_ready or state change.
  - Reaching WAIT_MAX -> ERROR on the next edge; request strobes drop.
- mem_read and mem_write are never both 1.
- Reset mid-access drops requests immediately (asynchronous).

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT);
  - funct constants;
  - alu_ctrl encodings;
  - alu_src_b and pc_source encodings.
- One sub-module, alu_ctrl_dec: combinational funct -> alu_ctrl plus legal flag. Used in DECODE for the legality check and in EXEC_R.

Test Plan:
- Reset: hold reset=0 with run=1 -> state IDLE, all strobes 0, alu_ctrl=0010, instr_count=0. Release -> FETCH on the next edge, mem_read=1.
- R-type add: opcode=0x00, funct=0x20, mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R over 4 cycles; reg_write=1, reg_dst=1 only in WB_R; instr_count=1.
- lw with memory stall: opcode=0x23, mem_ready low for 2 cycles in MEM_RD -> mem_read=1, iord=1 held 3 cycles; WB_M asserts mem_to_reg=1; 7 cycles total.
- beq: zero=1 -> pc_write=1, pc_source=01 in BRANCH. Repeat with zero=0 -> pc_write=0. Both cases 3 cycles, count +1.
- Errors:
  - opcode=0x3E -> ERROR after DECODE, err=1 sticky, no strobes.
  - Separately, mem_ready=0 for 8 cycles in FETCH -> ERROR.
- Halt and run gating:
  - run=0 during EXEC_I -> completes WB_I, then IDLE.
  - run=1 then opcode 0x3F -> halted=1, count increments once, and the FSM stays in HALT.
